mul_sequencer: RTL and testbench



---
 rtl/mul_sequencer_if.sv | 23 ++
 rtl/mul_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mul_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Core-side handshake between the decoder/datapath and the multi-cycle multiply
// sequencer: request, operands, stall and register-file write-back controls.
interface mul_sequencer_if;
  logic        start;
  logic [3:0]  mulop;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        stall;
  logic [31:0] result;
  logic        writelo;
  logic        writehi;
  logic        illegalop;

  modport master (
    output start, mulop, srca, srcb,
    input  stall, result, writelo, writehi, illegalop
  );

  modport slave (
    input  start, mulop, srca, srcb,
    output stall, result, writelo, writehi, illegalop
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add 32x32 multiply controller: stalls the core, iterates 32 times,
// fixes the sign for SMULL, then writes the low word and (for long ops) the high word.
module mul_sequencer (
  input logic            clk,
  input logic            reset,
  mul_sequencer_if.slave bus
);

  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    WBLO = 3'd3,
    WBHI = 3'd4
  } state_t;

  // 0x80000000 maps to itself, which read as unsigned is exactly 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? (~v + 32'd1) : v;
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  op_r;
  logic [31:0] mcand_r;
  logic [31:0] mplier_r;
  logic        neg_r;
  logic [63:0] prod_r;
  logic [4:0]  cnt_r;
  logic [31:0] result_r;
  logic        writelo_r;
  logic        writehi_r;
  logic        legal_s;
  logic        smull_s;
  logic        long_s;
  logic        stall_s;
  logic        illegal_s;
  logic [63:0] addend_s;
  logic [63:0] fixed_s;

  assign smull_s  = (bus.mulop == OP_SMULL);
  assign long_s   = (op_r == OP_UMULL) || (op_r == OP_SMULL);
  assign addend_s = {32'd0, mcand_r} << cnt_r;
  assign fixed_s  = neg_r ? (~prod_r + 64'd1) : prod_r;

  // Decode the requested operation code.
  always_comb begin
    legal_s = 1'b0;
    case (bus.mulop)
      OP_MUL, OP_UMULL, OP_SMULL: legal_s = 1'b1;
      default:                    legal_s = 1'b0;
    endcase
  end

  // Next-state, stall and illegal-op decode.
  always_comb begin
    state_s   = state_r;
    stall_s   = 1'b0;
    illegal_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (legal_s) begin
            state_s = RUN;
            stall_s = 1'b1;
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        stall_s = 1'b1;
        if (cnt_r == 5'd31) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX: begin
        stall_s = 1'b1;
        state_s = WBLO;
      end
      WBLO: begin
        // Last cycle of a MUL releases the core so the pipeline advances on this edge.
        if (long_s) begin
          stall_s = 1'b1;
          state_s = WBHI;
        end else begin
          state_s = IDLE;
        end
      end
      WBHI:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign bus.stall     = stall_s & ~reset;
  assign bus.illegalop = illegal_s & ~reset;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and shift-add accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r     <= 4'd0;
      mcand_r  <= 32'd0;
      mplier_r <= 32'd0;
      neg_r    <= 1'b0;
      prod_r   <= 64'd0;
      cnt_r    <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && legal_s) begin
            op_r     <= bus.mulop;
            mcand_r  <= magnitude(bus.srca, smull_s);
            mplier_r <= magnitude(bus.srcb, smull_s);
            neg_r    <= smull_s & (bus.srca[31] ^ bus.srcb[31]);
            prod_r   <= 64'd0;
            cnt_r    <= 5'd0;
          end
        end
        RUN: begin
          if (mplier_r[0]) begin
            prod_r <= prod_r + addend_s;
          end
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + 5'd1;
        end
        FIX:     prod_r <= fixed_s;
        default: ;
      endcase
    end
  end

  // Write-back outputs are loaded one edge ahead so they are stable for the whole write cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_r  <= 32'd0;
      writelo_r <= 1'b0;
      writehi_r <= 1'b0;
    end else begin
      writelo_r <= (state_r == FIX);
      writehi_r <= (state_r == WBLO) && long_s;
      if (state_r == FIX) begin
        result_r <= fixed_s[31:0];
      end else if ((state_r == WBLO) && long_s) begin
        result_r <= prod_r[63:32];
      end else begin
        result_r <= 32'd0;
      end
    end
  end

  assign bus.result  = result_r;
  assign bus.writelo = writelo_r;
  assign bus.writehi = writehi_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: cycle-accurate stall/write checks per
// operation plus a scoreboard of expected write-back words.
module tb_mul_sequencer;

  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0111;

  typedef struct {
    logic        hi;
    logic [31:0] val;
  } wb_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   wlo_cnt = 0;
  int   whi_cnt = 0;
  wb_t  sb_q[$];

  mul_sequencer_if bus ();

  mul_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        ua;
    logic [63:0]        ub;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (op == OP_SMULL) return sa * sb;
    return ua * ub;
  endfunction

  // Scoreboard: every write-back must match the next expected word.
  always @(negedge clk) begin
    if (!reset && (bus.writelo || bus.writehi)) begin
      wb_t e;
      if (bus.writelo) wlo_cnt++;
      if (bus.writehi) whi_cnt++;
      total++;
      if (bus.writelo && bus.writehi) begin
        bad++;
        $display("FAIL both_writes: writelo=%0b writehi=%0b required not both", bus.writelo, bus.writehi);
      end
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: lo=%0b hi=%0b result=%h required no write", bus.writelo, bus.writehi, bus.result);
      end else begin
        e = sb_q.pop_front();
        if (bus.writehi !== e.hi || bus.result !== e.val) begin
          bad++;
          $display("FAIL wb_data: hi=%0b result=%h required hi=%0b result=%h", bus.writehi, bus.result, e.hi, e.val);
        end
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string name);
    logic is_long;
    logic exp_stall;
    int   last;
    wb_t  e;
    is_long = (op != OP_MUL);
    last    = is_long ? 35 : 34;
    e.hi = 1'b0; e.val = exp_lo; sb_q.push_back(e);
    if (is_long) begin
      e.hi = 1'b1; e.val = exp_hi; sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mulop = op; bus.srca = a; bus.srcb = b;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      exp_stall = (c <= 33) || (c == 34 && is_long);
      total++;
      if (bus.stall !== exp_stall) begin
        bad++;
        $display("FAIL %s_stall c%0d: got %0b required %0b", name, c, bus.stall, exp_stall);
      end
      total++;
      if (bus.writelo !== (c == 34)) begin
        bad++;
        $display("FAIL %s_writelo c%0d: got %0b required %0b", name, c, bus.writelo, (c == 34));
      end
      total++;
      if (bus.writehi !== (is_long && c == 35)) begin
        bad++;
        $display("FAIL %s_writehi c%0d: got %0b required %0b", name, c, bus.writehi, (is_long && c == 35));
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.mulop = 4'd0; bus.srca = 32'd0; bus.srcb = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.stall, bus.writelo, bus.writehi, bus.illegalop} !== 4'b0000 || bus.result !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: stall=%0b lo=%0b hi=%0b ill=%0b result=%h required all 0",
               bus.stall, bus.writelo, bus.writehi, bus.illegalop, bus.result);
    end
    reset = 1'b0;
  endtask

  task automatic test_illegal();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mulop = 4'b1011; bus.srca = 32'd5; bus.srcb = 32'd9;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (bus.illegalop !== 1'b1 || bus.stall !== 1'b0) begin
        bad++;
        $display("FAIL illegal c%0d: illegalop=%0b stall=%0b required 1 0", c, bus.illegalop, bus.stall);
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.illegalop !== 1'b0 || bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL illegal_release: illegalop=%0b stall=%0b required 0 0", bus.illegalop, bus.stall);
    end
  endtask

  task automatic test_spec_vectors();
    run_op(OP_MUL,   32'd7,          32'd6,          32'h0000002A, 32'h0, "mul7x6");
    run_op(OP_UMULL, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 32'hFFFFFFFE, "umull_max");
    run_op(OP_SMULL, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFA, 32'hFFFFFFFF, "smull_neg");
    run_op(OP_SMULL, 32'h80000000,   32'h80000000,   32'h00000000, 32'h40000000, "smull_min");
  endtask

  task automatic test_back_to_back();
    int lo0;
    int hi0;
    lo0 = wlo_cnt; hi0 = whi_cnt;
    run_op(OP_MUL, 32'h12345678, 32'h9ABCDEF1, 32'h12345678 * 32'h9ABCDEF1, 32'h0, "b2b_first");
    total++;
    if (wlo_cnt - lo0 !== 1 || whi_cnt - hi0 !== 0) begin
      bad++;
      $display("FAIL b2b_single_seq: lo_writes=%0d hi_writes=%0d required 1 0", wlo_cnt - lo0, whi_cnt - hi0);
    end
    @(negedge clk);
    total++;
    if (bus.stall !== 1'b0 || bus.writelo !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap: stall=%0b writelo=%0b required 0 0", bus.stall, bus.writelo);
    end
    run_op(OP_UMULL, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 32'h00000000, "b2b_second");
    total++;
    if (wlo_cnt - lo0 !== 2 || whi_cnt - hi0 !== 1) begin
      bad++;
      $display("FAIL b2b_second_seq: lo_writes=%0d hi_writes=%0d required 2 1", wlo_cnt - lo0, whi_cnt - hi0);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ops[3];
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    ops[0] = OP_MUL; ops[1] = OP_UMULL; ops[2] = OP_SMULL;
    for (int i = 0; i < 6; i++) begin
      op = ops[$urandom_range(2, 0)];
      a  = $urandom;
      b  = $urandom;
      p  = model(op, a, b);
      run_op(op, a, b, p[31:0], p[63:32], "rand");
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mulop = OP_UMULL; bus.srca = 32'hDEADBEEF; bus.srcb = 32'h01234567;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({bus.stall, bus.writelo, bus.writehi, bus.illegalop} !== 4'b0000 || bus.result !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: stall=%0b lo=%0b hi=%0b ill=%0b result=%h required all 0",
               bus.stall, bus.writelo, bus.writehi, bus.illegalop, bus.result);
    end
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total++;
      if (bus.writelo !== 1'b0 || bus.writehi !== 1'b0 || bus.stall !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_after c%0d: lo=%0b hi=%0b stall=%0b required 0 0 0", c, bus.writelo, bus.writehi, bus.stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_spec_vectors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
